// File: rtl/aes_pkg.sv
// Shared AES constants, SubBytes FSM state type and GF(2^8) arithmetic helpers.
package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sb_state_e;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box core: forward (encrypt=1) or inverse (encrypt=0) substitution of one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic       encrypt,
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    logic [7:0] fwd_inv;
    logic [7:0] inv_aff;

    always_comb begin
        fwd_inv = gf_inv(byte_in);
        // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
        inv_aff = {byte_in[6:0], byte_in[7]}   ^
                  {byte_in[4:0], byte_in[7:5]} ^
                  {byte_in[1:0], byte_in[7:2]} ^ 8'h05;
        if (encrypt) begin
            byte_out = fwd_inv ^
                       {fwd_inv[6:0], fwd_inv[7]}   ^
                       {fwd_inv[5:0], fwd_inv[7:6]} ^
                       {fwd_inv[4:0], fwd_inv[7:5]} ^
                       {fwd_inv[3:0], fwd_inv[7:4]} ^ 8'h63;
        end else begin
            byte_out = gf_inv(inv_aff);
        end
    end

endmodule

// File: rtl/subbytes_serial.sv
// Serial SubBytes over a 128-bit state: 16 busy cycles (8 with SUBBYTES_DUAL_LANE_EN), result held
// in DONE until out_ready; no new state is accepted until the result has been consumed.
module subbytes_serial
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   encrypt,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   busy
);

`ifdef SUBBYTES_DUAL_LANE_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif
    localparam logic [3:0] IDX_STEP = 4'(LANES);
    localparam logic [3:0] IDX_LAST = 4'(AES_NUM_BYTES - LANES);

    sb_state_e                     state_q, state_d;
    logic [3:0]                    idx_q, idx_d;
    logic                          enc_q, enc_d;
    logic [AES_NUM_BYTES-1:0][7:0] work_q, work_d;
    logic [LANES-1:0][7:0]         lane_in;
    logic [LANES-1:0][7:0]         lane_out;

    // Byte n of the state lives in work_q[15-n], so byte 0 sits at [127:120].
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_in[g] = work_q[4'(AES_NUM_BYTES - 1 - g) - idx_q];

        aes_sbox u_sbox (
            .encrypt  (enc_q),
            .byte_in  (lane_in[g]),
            .byte_out (lane_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            enc_q   <= 1'b1;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            enc_q   <= enc_d;
            work_q  <= work_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        enc_d     = enc_q;
        work_d    = work_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = state_in;
                    enc_d   = encrypt;
                    idx_d   = 4'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    work_d[4'(AES_NUM_BYTES - 1 - l) - idx_q] = lane_out[l];
                end
                // Index stays put on the final write so it never wraps.
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_STEP;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state_out = work_q;

endmodule

// File: tb/tb_subbytes_serial.sv
// Directed bench for subbytes_serial with an expected-result queue and an independent S-box model.
`timescale 1ns/1ps
module tb_subbytes_serial;

    logic         clk = 1'b0;
    logic         rst;
    logic         encrypt;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

`ifdef SUBBYTES_DUAL_LANE_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 17;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   fwd_tbl[256];
    logic [7:0]   inv_tbl[256];

    always #5 clk = ~clk;

    subbytes_serial dut (
        .clk       (clk),
        .rst       (rst),
        .encrypt   (encrypt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Polynomial product then reduction by 0x11b.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ ({8'h00, a} << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] v;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (ref_mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
            end
            fwd_tbl[x] = s;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic enc, input logic [127:0] d);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) begin
            r[127 - 8*b -: 8] = enc ? fwd_tbl[d[127 - 8*b -: 8]] : inv_tbl[d[127 - 8*b -: 8]];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic accept_op(input logic enc, input logic [127:0] data, input logic [127:0] exp,
                             input bit push);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        encrypt  = enc;
        state_in = data;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        state_in = ~data;
        encrypt  = ~enc;
        if (push) exp_q.push_back(exp);
        chk("busy_after_accept", busy, 1);
        chk("in_ready_in_busy", in_ready, 0);
    endtask

    // Accept cycle is T; the cycle right after the accepting edge is T+1.
    task automatic wait_done();
        int cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 128'(cyc), 128'(LAT));
        chk("busy_in_done", busy, 0);
    endtask

    task automatic consume(input int stall, input bit hold_valid);
        logic [127:0] snap = state_out;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_data", state_out, snap);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        if (hold_valid) begin
            in_valid = 1'b1;
            state_in = 128'h0;
        end
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard: observed 0 pending results expected at least 1");
        end
        if (exp_q.size() > 0) chk("result", state_out, exp_q.pop_front());
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("handoff_out_valid", out_valid, 0);
        chk("handoff_in_ready", in_ready, 1);
        chk("handoff_no_accept", busy, 0);
    endtask

    initial begin
        logic [127:0] d;
        logic         e;
        int           seen;

        rst       = 1'b1;
        encrypt   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = 128'h0;
        build_tables();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_state_out", state_out, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with literal expectations.
        accept_op(1'b1, 128'h0, {16{8'h63}}, 1);
        wait_done();
        consume(0, 0);

        accept_op(1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h637c777bf26b6fc53001672bfed7ab76, 1);
        wait_done();
        consume(1, 0);

        accept_op(1'b0, {16{8'h63}}, 128'h0, 1);
        wait_done();
        consume(0, 0);

        // Long stall with in_valid held over the handoff, then a back-to-back accept.
        accept_op(1'b0, {16{8'hed}}, {16{8'h53}}, 1);
        wait_done();
        consume(10, 1);

        for (int k = 0; k < 4; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            e = 1'(k % 2);
            accept_op(e, d, model(e, d), 1);
            wait_done();
            consume(int'($urandom_range(0, 3)), 0);
        end

        // Reset during BUSY, in the cycle T+5.
        accept_op(1'b1, 128'hdeadbeef_00112233_44556677_8899aabb, 128'h0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_state_out", state_out, 128'h0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_output", 128'(seen), 128'h0);

        d = 128'h000102030405060708090a0b0c0d0e0f;
        accept_op(1'b1, d, 128'h637c777bf26b6fc53001672bfed7ab76, 1);
        wait_done();
        consume(0, 0);

        // Reset while the result waits in DONE.
        accept_op(1'b0, {16{8'h16}}, 128'h0, 0);
        wait_done();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("donerst_out_valid", out_valid, 0);
        chk("donerst_state_out", state_out, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        d = {$urandom, $urandom, $urandom, $urandom};
        accept_op(1'b0, d, model(1'b0, d), 1);
        wait_done();
        consume(2, 0);

        chk("queue_drained", 128'(exp_q.size()), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
